// File: rtl/elastic_buffer.sv
// elastic_buffer: DEPTH-entry valid/ready FIFO stage; ready_in comes from registered state only.
// Optional macro ELASTIC_BYPASS_EN adds a zero-latency path from data_in to data_out when empty.
module elastic_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    output logic                         ready_in,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic                         valid_out,
    input  logic                         ready_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("elastic_buffer: DEPTH must be a power of 2 and >= 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
        $error("elastic_buffer: AF_LEVEL must be within 1..DEPTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  stored;
    logic                  push;
    logic                  pop;
    logic                  wr_en;
    logic                  rd_en;

    assign stored   = (count != '0);
    assign ready_in = !rst && (count != FULL_CNT);
    assign push     = valid_in && ready_in;
    assign pop      = valid_out && ready_out;

`ifdef ELASTIC_BYPASS_EN
    logic bypass;

    // An empty buffer forwards the incoming beat directly; it is only stored if not taken.
    assign bypass    = !stored && valid_in;
    assign valid_out = !rst && (stored || valid_in);
    assign data_out  = bypass ? data_in : mem[rd_ptr];
    assign wr_en     = push && !(bypass && ready_out);
    assign rd_en     = pop && stored;
`else
    assign valid_out = !rst && stored;
    assign data_out  = mem[rd_ptr];
    assign wr_en     = push;
    assign rd_en     = pop;
`endif

    assign level       = rst ? '0 : count;
    assign almost_full = !rst && (count >= AF_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; count gates whether any entry is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_elastic_buffer.sv
// tb_elastic_buffer: directed vector table plus hand-written sequences for the elastic_buffer
// default build (DEPTH=4, AF_LEVEL=3, no bypass).
module tb_elastic_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int LW    = $clog2(DEPTH+1);
    localparam int NVEC  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_in;
    logic          valid_out;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic [LW-1:0] level;
    logic          almost_full;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       vi;
        logic       ro;
        logic [7:0] din;
        logic       e_ri;
        logic       e_vo;
        logic [7:0] e_do;
        logic [2:0] e_lvl;
        logic       e_af;
    } vec_t;

    vec_t vecs [NVEC];

    logic [DW-1:0] sb [$];
    int            sent;
    int            got;
    int            cyc;
    int            mlvl;
    logic          p_vi;
    logic          p_ro;
    logic          do_push;
    logic          do_pop;
    logic          prev_hold;
    logic [DW-1:0] prev_data;

    always #5 clk = ~clk;

    elastic_buffer #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .AF_LEVEL  (AF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .level      (level),
        .almost_full(almost_full)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //            rst   vi    ro    din    e_ri  e_vo  e_do   lvl   af
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h56, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b1, 1'b1, 8'h01, 3'd1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b1, 8'h02, 3'd1, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h03, 3'd1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'hA0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b1, 8'hA0, 3'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 8'hA2, 1'b1, 1'b1, 8'hA0, 3'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 8'hA3, 1'b1, 1'b1, 8'hA0, 3'd3, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'hA4, 1'b0, 1'b1, 8'hA0, 3'd4, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 8'hA4, 1'b1, 1'b1, 8'hA1, 3'd3, 1'b1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA1, 3'd4, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA2, 3'd3, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA3, 3'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA4, 3'd1, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0};

        rst       = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = '0;
        #1;

        // Reset, pass-through, fill to full, pop-while-full and drain with wrap.
        for (int i = 0; i < NVEC; i++) begin
            rst       = vecs[i].rst;
            valid_in  = vecs[i].vi;
            ready_out = vecs[i].ro;
            data_in   = {24'h0, vecs[i].din};
            @(negedge clk);
            check($sformatf("v%0d ready_in", i), 32'(ready_in), 32'(vecs[i].e_ri));
            check($sformatf("v%0d valid_out", i), 32'(valid_out), 32'(vecs[i].e_vo));
            check($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
            check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
            if (vecs[i].e_vo) begin
                check($sformatf("v%0d data_out", i), data_out, {24'h0, vecs[i].e_do});
            end
            tick();
        end

        // Pseudo-random valid/ready traffic against a queue model.
        valid_in  = 1'b0;
        ready_out = 1'b0;
        sent      = 0;
        got       = 0;
        cyc       = 0;
        mlvl      = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        while (got < 20 && cyc < 400) begin
            p_vi      = (sent < 20) && ($urandom_range(0, 3) != 0);
            p_ro      = ($urandom_range(0, 2) != 0);
            valid_in  = p_vi;
            ready_out = p_ro;
            data_in   = 32'hC0DE_0000 + 32'(sent);
            @(negedge clk);
            check("rand ready_in", 32'(ready_in), 32'(mlvl != DEPTH));
            check("rand valid_out", 32'(valid_out), 32'(mlvl != 0));
            check("rand level", 32'(level), 32'(mlvl));
            check("rand almost_full", 32'(almost_full), 32'(mlvl >= AF));
            if (mlvl != 0) begin
                check("rand data_out order", data_out, sb[0]);
            end
            if (prev_hold) begin
                check("rand hold stable", data_out, prev_data);
            end
            do_pop    = p_ro && (mlvl != 0);
            do_push   = p_vi && (mlvl != DEPTH);
            prev_hold = (mlvl != 0) && !p_ro;
            prev_data = (mlvl != 0) ? sb[0] : '0;
            tick();
            if (do_pop) begin
                void'(sb.pop_front());
                mlvl--;
                got++;
            end
            if (do_push) begin
                sb.push_back(32'hC0DE_0000 + 32'(sent));
                mlvl++;
                sent++;
            end
            cyc++;
        end
        check("rand beats received", 32'(got), 32'd20);

        // Reset with three beats stored: none of them may ever reappear.
        valid_in  = 1'b0;
        ready_out = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            data_in  = 32'hB0 + 32'(i);
            tick();
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("pre-reset level", 32'(level), 32'd3);
        check("pre-reset data_out", data_out, 32'hB0);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("in-reset ready_in", 32'(ready_in), 32'd0);
        check("in-reset valid_out", 32'(valid_out), 32'd0);
        check("in-reset level", 32'(level), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post-reset level", 32'(level), 32'd0);
        check("post-reset valid_out", 32'(valid_out), 32'd0);
        check("post-reset ready_in", 32'(ready_in), 32'd1);
        check("post-reset almost_full", 32'(almost_full), 32'd0);
        tick();
        ready_out = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("no stale beat c%0d", i), 32'(valid_out), 32'd0);
            tick();
        end
        valid_in = 1'b1;
        data_in  = 32'hC1;
        tick();
        valid_in = 1'b0;
        @(negedge clk);
        check("first beat after reset valid", 32'(valid_out), 32'd1);
        check("first beat after reset data", data_out, 32'hC1);
        check("first beat after reset level", 32'(level), 32'd1);
        tick();
        @(negedge clk);
        check("drained after reset valid", 32'(valid_out), 32'd0);
        check("drained after reset level", 32'(level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
